led_matrix_scanner: RTL and testbench



---
 rtl/matrix_pkg.sv | 19 +
 rtl/scan_timer.sv | 49 ++++
 rtl/led_matrix_scanner.sv | 72 +++++++
 tb/tb_led_matrix_scanner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared geometry and row-slice helper for the 12x16 LED dot matrix.
package matrix_pkg;

  localparam int MATRIX_ROWS = 12;
  localparam int MATRIX_COLS = 16;
  localparam int FRAME_W     = 192;
  localparam int ROW_IDX_W   = 4;

  // Row r (0 = top) lives in the MSB-first word frame[191-16r -: 16].
  function automatic logic [MATRIX_COLS-1:0] frame_row(
    input logic [FRAME_W-1:0]   frame,
    input logic [ROW_IDX_W-1:0] r
  );
    logic [FRAME_W-1:0] w_shifted;
    w_shifted = frame << (MATRIX_COLS * int'(r));
    return w_shifted[FRAME_W-1 -: MATRIX_COLS];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row-slot divider and row counter for the matrix scan, with blanking window.
module scan_timer
  import matrix_pkg::*;
#(
  parameter int CLK_DIV      = 4096,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  output logic [ROW_IDX_W-1:0] o_row_idx,
  output logic                 o_slot_start,
  output logic                 o_frame_slot_start,
  output logic                 o_blank
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]     BLANK_V  = DIV_W'(BLANK_CYCLES);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(MATRIX_ROWS - 1);

  logic [DIV_W-1:0]     r_div_cnt;
  logic [ROW_IDX_W-1:0] r_row_idx;

  // Advance the slot divider and the row counter only while scanning is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_row_idx <= '0;
    end else if (i_enable) begin
      if (r_div_cnt == DIV_MAX) begin
        r_div_cnt <= '0;
        r_row_idx <= (r_row_idx == ROW_LAST) ? '0 : r_row_idx + ROW_IDX_W'(1);
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  // slot_start marks an enabled edge at a slot boundary; frame_slot_start marks
  // the scan position being the very first cycle of a frame.
  always_comb begin
    o_row_idx          = r_row_idx;
    o_slot_start       = i_enable && (r_div_cnt == '0);
    o_frame_slot_start = (r_div_cnt == '0) && (r_row_idx == '0);
    o_blank            = (r_div_cnt < BLANK_V) || !i_enable;
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Tear-free time-multiplexed row driver: snapshots the composed frame once per
// refresh frame and scans it out one row per slot with a dark gap per slot.
module led_matrix_scanner
  import matrix_pkg::*;
#(
  parameter int CLK_DIV        = 4096,
  parameter int BLANK_CYCLES   = 64,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [FRAME_W-1:0]     frame,
  output logic [MATRIX_ROWS-1:0] row_sel,
  output logic [MATRIX_COLS-1:0] col_data,
  output logic [ROW_IDX_W-1:0]   row_idx,
  output logic                   frame_start
);

  logic [ROW_IDX_W-1:0] w_row_idx;
  logic                 w_slot_start;
  logic                 w_frame_slot_start;
  logic                 w_blank;
  logic                 w_snap;

  logic [FRAME_W-1:0]   r_shadow;
  logic                 r_frame_start;

  scan_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_scan_timer (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_enable           (enable),
    .o_row_idx          (w_row_idx),
    .o_slot_start       (w_slot_start),
    .o_frame_slot_start (w_frame_slot_start),
    .o_blank            (w_blank)
  );

  // The only edge that ever samples frame: enabled, at the start of row 0.
  assign w_snap = w_slot_start && w_frame_slot_start;

  // Shadow buffer load and the one-cycle frame_start pulse that reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (w_snap) begin
        r_shadow <= frame;
      end
    end
  end

  // Pin decode purely from register state so rows and columns switch together.
  always_comb begin
    logic [MATRIX_ROWS-1:0] w_onehot;
    w_onehot    = MATRIX_ROWS'(1) << w_row_idx;
    row_sel     = ROW_ACTIVE_LOW ? '1 : '0;
    col_data    = '0;
    if (!w_blank) begin
      row_sel  = ROW_ACTIVE_LOW ? ~w_onehot : w_onehot;
      col_data = frame_row(r_shadow, w_row_idx);
    end
    row_idx     = w_row_idx;
    frame_start = r_frame_start;
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with CLK_DIV=4, BLANK_CYCLES=1, active-low rows.
module tb_led_matrix_scanner;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [191:0] frame;
  logic [11:0]  row_sel;
  logic [15:0]  col_data;
  logic [3:0]   row_idx;
  logic         frame_start;

  int n_checks;
  int n_pass;
  int cyc;
  bit found;

  led_matrix_scanner #(
    .CLK_DIV        (4),
    .BLANK_CYCLES   (1),
    .ROW_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame       (frame),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_row(input int r, input logic [15:0] w);
    frame[191-16*r -: 16] = w;
  endtask

  // Advance to the sampling point (falling edge) of enabled cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    found    = 1'b0;
    rst_n    = 1'b0;
    enable   = 1'b1;
    frame    = '1;

    // Reset held with all-ones frame and enable high.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_row_sel", 32'(row_sel), 32'h0FFF);
      check("rst_col", 32'(col_data), 32'h0);
      check("rst_fs", 32'(frame_start), 32'h0);
    end

    // Test frame: row0 A5A5, row5 00FF, row11 0001, others 0x0100|r.
    for (int r = 0; r < 12; r++) set_row(r, 16'h0100 | 16'(r));
    set_row(0, 16'hA5A5);
    set_row(5, 16'h00FF);
    set_row(11, 16'h0001);
    rst_n = 1'b1;
    #1;
    check("c0_row_sel", 32'(row_sel), 32'h0FFF);
    check("c0_col", 32'(col_data), 32'h0);
    check("c0_fs", 32'(frame_start), 32'h0);

    goto(1);
    check("c1_fs", 32'(frame_start), 32'h1);
    check("c1_row_sel", 32'(row_sel), 32'h0FFE);
    check("c1_col", 32'(col_data), 32'hA5A5);
    goto(2);
    check("c2_fs", 32'(frame_start), 32'h0);
    check("c2_col", 32'(col_data), 32'hA5A5);
    goto(3);
    check("c3_row_sel", 32'(row_sel), 32'h0FFE);
    goto(4);
    check("c4_row_sel", 32'(row_sel), 32'h0FFF);
    check("c4_col", 32'(col_data), 32'h0);
    check("c4_row_idx", 32'(row_idx), 32'h1);

    goto(10);
    set_row(5, 16'hFF00);
    goto(21);
    check("c21_row_sel", 32'(row_sel), 32'h0FDF);
    check("c21_col_old", 32'(col_data), 32'h00FF);

    goto(45);
    check("c45_row_sel", 32'(row_sel), 32'h07FF);
    check("c45_col", 32'(col_data), 32'h0001);
    goto(47);
    check("c47_col", 32'(col_data), 32'h0001);
    check("c47_row_idx", 32'(row_idx), 32'hB);
    goto(48);
    check("c48_row_idx", 32'(row_idx), 32'h0);
    check("c48_fs", 32'(frame_start), 32'h0);
    check("c48_row_sel", 32'(row_sel), 32'h0FFF);
    goto(49);
    check("c49_fs", 32'(frame_start), 32'h1);
    check("c49_col", 32'(col_data), 32'hA5A5);
    goto(50);
    check("c50_fs", 32'(frame_start), 32'h0);
    goto(69);
    check("c69_row_sel", 32'(row_sel), 32'h0FDF);
    check("c69_col_new", 32'(col_data), 32'hFF00);
    goto(97);
    check("c97_fs", 32'(frame_start), 32'h1);

    // Disable at row 3, div_cnt 2 of frame 2.
    goto(110);
    check("dis_pre_row_sel", 32'(row_sel), 32'h0FF7);
    check("dis_pre_col", 32'(col_data), 32'h0103);
    enable = 1'b0;
    set_row(3, 16'hDEAD);
    #1;
    check("dis_row_sel", 32'(row_sel), 32'h0FFF);
    check("dis_col", 32'(col_data), 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("dis_hold_row_sel", 32'(row_sel), 32'h0FFF);
      check("dis_hold_row_idx", 32'(row_idx), 32'h3);
      check("dis_hold_fs", 32'(frame_start), 32'h0);
    end
    enable = 1'b1;
    #1;
    check("reen_row_sel", 32'(row_sel), 32'h0FF7);
    check("reen_col", 32'(col_data), 32'h0103);
    step();
    check("reen_d3_col", 32'(col_data), 32'h0103);
    check("reen_d3_row_idx", 32'(row_idx), 32'h3);
    step();
    check("reen_r4_idx", 32'(row_idx), 32'h4);
    check("reen_r4_blank", 32'(row_sel), 32'h0FFF);
    step();
    check("reen_r4_row_sel", 32'(row_sel), 32'h0FEF);
    check("reen_r4_col", 32'(col_data), 32'h0104);

    // Reset in the middle of row 7.
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (row_idx == 4'd7) found = 1'b1;
    end
    check("reach_row7", 32'(found), 32'h1);
    step();
    check("r7_row_sel", 32'(row_sel), 32'h0F7F);
    check("r7_col", 32'(col_data), 32'h0107);
    rst_n = 1'b0;
    #1;
    check("mrst_row_sel", 32'(row_sel), 32'h0FFF);
    check("mrst_col", 32'(col_data), 32'h0);
    check("mrst_row_idx", 32'(row_idx), 32'h0);
    set_row(0, 16'h3C3C);
    step();
    step();
    check("mrst_hold_row_sel", 32'(row_sel), 32'h0FFF);
    rst_n = 1'b1;
    #1;
    check("mrel_c0_fs", 32'(frame_start), 32'h0);
    step();
    check("mrel_c1_fs", 32'(frame_start), 32'h1);
    check("mrel_c1_row_sel", 32'(row_sel), 32'h0FFE);
    check("mrel_c1_col", 32'(col_data), 32'h3C3C);
    step();
    check("mrel_c2_fs", 32'(frame_start), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
